// File: rtl/bcd_convert_seq.sv
// -----------------------------------------------------------------------------
// bcd_convert_seq
//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//   Sits behind the timer state register and feeds packed BCD digits to the
//   7-segment display driver. The published result only changes on the DONE
//   edge, so the display never sees intermediate scratch values.
//
//   Parameters
//     WIDTH   binary input width (timer register width)
//     DIGITS  BCD digits produced; 10**DIGITS must exceed 2**WIDTH-1
//
//   Ports
//     clk        in   rising-edge clock
//     rst        in   asynchronous, active-high reset
//     i_start    in   conversion request, accepted only while o_busy=0
//     i_bin_in   in   binary value, sampled on an accepted start
//     o_busy     out  high while a conversion is in progress (SHIFT, DONE)
//     o_done     out  one-cycle pulse: o_bcd_out has just been updated
//     o_bcd_out  out  packed BCD, digit 0 (units) in [3:0]
//     o_blank    out  leading-zero mask, 1 = digit blank (BCD_BLANK_EN only)
//
//   Build option
//     BCD_BLANK_EN  when defined, adds o_blank, registered with o_bcd_out.
//                   blank[i]=1 iff digit i and all higher digits are 0 (i>=1);
//                   blank[0] is always 0 so the value 0 still shows one "0".
// -----------------------------------------------------------------------------
module bcd_convert_seq #(
   parameter int WIDTH  = 25,
   parameter int DIGITS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [WIDTH-1:0]      i_bin_in,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [4*DIGITS-1:0]   o_bcd_out
`ifdef BCD_BLANK_EN
   ,
   output logic [DIGITS-1:0]     o_blank
`endif
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int BW = 4 * DIGITS;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [WIDTH-1:0]    r_shreg;
   logic [BW-1:0]       r_scratch;
   logic [BW-1:0]       w_adj;
   logic [BW+WIDTH-1:0] w_shifted;
   logic [CW-1:0]       r_count;
   logic [BW-1:0]       r_bcd;
   logic                r_done;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking (<=) so every register samples the
   // pre-edge values of the others, independent of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   // NOTE: every always_comb output gets a default before the case, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_next = S_SHIFT;
         // r_count counts remaining shifts; the edge that performs the last one
         // also moves to DONE.
         S_SHIFT: if (r_count == CW'(1)) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Add-3 correction: any digit >= 5 would become >= 10 after the doubling
   // shift, so it is pre-biased by 3 to carry correctly into the next digit.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_adj = r_scratch;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_scratch[4*d +: 4] >= 4'd5)
            w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
      end
   end

   // {scratch, shreg} moves left as one register: the MSB of the latched binary
   // value enters the LSB of digit 0.
   assign w_shifted = {w_adj, r_shreg} << 1;

   // ---------------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shreg   <= '0;
         r_scratch <= '0;
         r_count   <= '0;
         r_bcd     <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= (r_state == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_shreg   <= i_bin_in;
                  r_scratch <= '0;
                  r_count   <= CW'(WIDTH);
               end
            end
            S_SHIFT: begin
               r_scratch <= w_shifted[BW+WIDTH-1:WIDTH];
               r_shreg   <= w_shifted[WIDTH-1:0];
               r_count   <= r_count - CW'(1);
            end
            S_DONE:  r_bcd <= r_scratch;
            default: ;
         endcase
      end
   end

`ifdef BCD_BLANK_EN
   // ---------------------------------------------------------------------------
   // Leading-zero blanking, registered together with the result
   // ---------------------------------------------------------------------------
   logic [DIGITS-1:0] w_blank;
   logic [DIGITS-1:0] r_blank;

   always_comb begin
      logic v_zero_above;
      w_blank      = '0;
      v_zero_above = 1'b1;
      // Walk down from the top digit; stop short of digit 0 so it never blanks.
      for (int i = DIGITS - 1; i >= 1; i--) begin
         v_zero_above = v_zero_above & (r_scratch[4*i +: 4] == 4'd0);
         w_blank[i]   = v_zero_above;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    r_blank <= '0;
      else if (r_state == S_DONE) r_blank <= w_blank;
   end

   assign o_blank = r_blank;
`endif

   assign o_busy    = (r_state != S_IDLE);
   assign o_done    = r_done;
   assign o_bcd_out = r_bcd;

endmodule
